inst_fetch_arbiter: RTL
=======================

INST_FETCH_ARBITER -- requirements
Module: inst_fetch_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1156, meaning the byte count of the instruction memory; valid addresses are 0..MEM_BYTES-1.
REQ-002 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port pc, input, 32: the pipeline fetch address.
REQ-005 SHALL have port fetch_req, input, 1: the pipeline requests an instruction this cycle.
REQ-006 SHALL have port mem_rdata, input, 32: the 4-byte big-endian read word from memory at mem_addr.
REQ-007 SHALL have port out_inst, output, 32: the instruction delivered to the pipeline.
REQ-008 SHALL have port fetch_stall, output, 1: the pipeline shall hold its PC.
REQ-009 SHALL have port ld_valid, input, 1: the loader offers a word.
REQ-010 SHALL have port ld_addr, input, 32: the loader word byte address.
REQ-011 SHALL have port ld_wdata, input, 32: the loader word.
REQ-012 SHALL have port ld_ready, output, 1: the arbiter accepts a loader word.
REQ-013 SHALL have port ld_done, input, 1: a one-cycle pulse marking the end of the program load.
REQ-014 SHALL have port mem_addr, output, 32: the memory byte address.
REQ-015 SHALL have port mem_we, output, 1: the memory byte write enable.
REQ-016 SHALL have port mem_wbyte, output, 8: the memory write byte.
REQ-017 SHALL have port oob_err, output, 1: a sticky loader address error flag.

Function
REQ-018 SHALL implement the FSM states IDLE, WR0, WR1, WR2 and WR3.
REQ-019 SHALL hold ld_ready=1 only in IDLE; a transfer is accepted when ld_valid&&ld_ready, and the FSM then goes IDLE->WR0 on the next edge.
REQ-020 SHALL latch ld_addr and ld_wdata at acceptance and ignore later changes on those inputs until the FSM returns to IDLE.
REQ-021 SHALL advance WR0->WR1->WR2->WR3->IDLE unconditionally, one state per cycle, so one word occupies exactly 4 cycles after acceptance.
REQ-022 SHALL drive, in WRk, mem_addr=latched_addr+k and mem_we=1, with mem_wbyte=ld_wdata[31:24], [23:16], [15:8] and [7:0] for k=0..3 respectively (big-endian).
REQ-023 SHALL drive, in IDLE, mem_addr=pc and mem_we=0.
REQ-024 SHALL give the loader priority: if ld_valid and fetch_req are both high in IDLE, it accepts the loader word, and the fetch that cycle still completes.
REQ-025 SHALL drive fetch_stall=1 in WR0..WR3 and while boot-hold is active (REQ-034); otherwise fetch_stall=0.
REQ-026 SHALL drive out_inst=mem_rdata when fetch_stall=0 and fetch_req=1; otherwise out_inst=32'b0 (bubble).
REQ-027 SHALL treat a word whose latched address has [1:0]!=0 or address+3>MEM_BYTES-1 as a bad word: the word still takes 4 WR cycles, mem_we stays 0 for those cycles, and oob_err is set to 1 and held until reset.
REQ-028 SHALL compute address arithmetic in 32 bits; when address+3 overflows past 32'hFFFFFFFF, the word is treated as out of bounds.
REQ-029 SHALL ignore ld_done in every state when BOOT_HOLD_EN is undefined.

Reset
REQ-030 SHALL, when reset=1 at a clock edge, put the FSM in IDLE, drop any word in flight (bytes already written stay in memory), and clear oob_err to 0.
REQ-031 SHALL drive the outputs to the following values in the cycle after reset: ld_ready=1, mem_we=0, mem_wbyte=0, mem_addr=pc, and out_inst=0.
REQ-032 SHALL have reset take priority over any ld_valid or ld_done seen in the same cycle.

Configuration
REQ-033 SHALL support the macro INST_FETCH_ARBITER_BOOT_HOLD_EN, which compiles the boot-hold feature in or out.
REQ-034 SHALL, with INST_FETCH_ARBITER_BOOT_HOLD_EN defined, set a boot_hold register to 1 on reset and clear it on the edge after ld_done=1 is seen in IDLE; while boot_hold=1, fetch_stall=1 and out_inst=0.
REQ-035 SHALL, without INST_FETCH_ARBITER_BOOT_HOLD_EN, contain no boot_hold register, and fetch_stall depends only on the FSM state.

Verification
REQ-036 SHALL cover a single load: ld_addr=0x10, ld_wdata=0xDEADBEEF accepted in cycle N -> bytes DE/AD/BE/EF are written at 0x10..0x13 in cycles N+1..N+4, ld_ready=0 in N+1..N+4, and ld_ready=1 in N+5.
REQ-037 SHALL cover a collision: fetch_req=1 and ld_valid=1 in IDLE -> the word is accepted, fetch_stall=1 for the next 4 cycles, and out_inst=0 during those cycles.
REQ-038 SHALL cover out-of-bounds loads: ld_addr=1154 or ld_addr=0x21 -> mem_we=0 for all 4 WR cycles, and oob_err=1 from the next cycle until reset.
REQ-039 SHALL cover reset mid-word: reset in WR1 -> the FSM is in IDLE, mem_we=0 and ld_ready=1 in the following cycle, and only bytes 0 and 1 of the word were written.
REQ-040 SHALL cover boot hold with the macro defined: after reset fetch_stall=1, and it stays 1 until ld_done pulses in IDLE; then fetch_stall=0 and out_inst equals mem_rdata at pc=0.
REQ-041 SHALL cover a back-to-back load: ld_valid held high with 2 words -> the second word is accepted at cycle N+5, so the two words complete 10 cycles after the first acceptance.

Source files
------------

// File: rtl/inst_fetch_arbiter.sv
// rtl/inst_fetch_arbiter.sv - instruction-memory port arbiter between pipeline fetch and program loader
//
// Shares one instruction-memory port between the pipeline fetch path and a
// word-oriented program loader. A loader word is written as four big-endian
// byte writes (WR0..WR3), and the fetch path is stalled while that happens.
// A loader word that is misaligned or outside MEM_BYTES is still sequenced
// through WR0..WR3, but it is never written and it sets the sticky oob_err.
//
// Optional feature macro: INST_FETCH_ARBITER_BOOT_HOLD_EN
//   When this macro is defined, fetch is held off from reset until ld_done is
//   seen in IDLE.
//
// Parameters:
//   MEM_BYTES   instruction memory size in bytes (valid addresses 0..MEM_BYTES-1)
// Ports:
//   clock       single clock, rising edge
//   reset       synchronous, active-high
//   pc          pipeline fetch byte address
//   fetch_req   pipeline wants an instruction this cycle
//   mem_rdata   big-endian 32-bit read word at mem_addr
//   out_inst    instruction to the pipeline (zero bubble when not delivered)
//   fetch_stall pipeline must hold its PC
//   ld_valid    loader offers a word
//   ld_addr     loader word byte address
//   ld_wdata    loader word
//   ld_ready    arbiter can accept a loader word (IDLE only)
//   ld_done     one-cycle end-of-load pulse
//   mem_addr    memory byte address
//   mem_we      memory byte write enable
//   mem_wbyte   memory write byte
//   oob_err     sticky bad-loader-address flag

module inst_fetch_arbiter #(
    parameter int MEM_BYTES = 1156
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        fetch_req,
    input  logic [31:0] mem_rdata,
    output logic [31:0] out_inst,
    output logic        fetch_stall,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ready,
    input  logic        ld_done,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wbyte,
    output logic        oob_err
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        WR1  = 3'd2,
        WR2  = 3'd3,
        WR3  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_bad;
    logic        r_oob_err;

    logic        w_accept;
    logic [32:0] w_last_byte;
    logic        w_bad;
    logic        w_boot_hold;

    assign w_accept = ld_valid && (r_state == IDLE);

    // The extra carry bit catches a word whose last byte wraps past 32'hFFFFFFFF.
    assign w_last_byte = {1'b0, ld_addr} + 33'd3;
    assign w_bad       = (ld_addr[1:0] != 2'b00) || w_last_byte[32]
                         || (w_last_byte[31:0] > LAST_ADDR);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_bad     <= 1'b0;
            r_oob_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr  <= ld_addr;
                r_wdata <= ld_wdata;
                r_bad   <= w_bad;
                if (w_bad) begin
                    r_oob_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_addr     = pc;
        mem_we       = 1'b0;
        mem_wbyte    = 8'd0;
        ld_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    w_next_state = WR0;
                end
            end
            WR0: begin
                mem_addr     = r_addr;
                mem_wbyte    = r_wdata[31:24];
                mem_we       = !r_bad;
                w_next_state = WR1;
            end
            WR1: begin
                mem_addr     = r_addr + 32'd1;
                mem_wbyte    = r_wdata[23:16];
                mem_we       = !r_bad;
                w_next_state = WR2;
            end
            WR2: begin
                mem_addr     = r_addr + 32'd2;
                mem_wbyte    = r_wdata[15:8];
                mem_we       = !r_bad;
                w_next_state = WR3;
            end
            WR3: begin
                mem_addr     = r_addr + 32'd3;
                mem_wbyte    = r_wdata[7:0];
                mem_we       = !r_bad;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

`ifdef INST_FETCH_ARBITER_BOOT_HOLD_EN
    logic r_boot_hold;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_boot_hold <= 1'b1;
        end else if ((r_state == IDLE) && ld_done) begin
            r_boot_hold <= 1'b0;
        end
    end

    assign w_boot_hold = r_boot_hold;
`else
    // ld_done has no function without boot hold.
    logic w_unused_ld_done;
    assign w_unused_ld_done = ld_done;
    assign w_boot_hold      = 1'b0;
`endif

    // The fetch path keeps running in IDLE even in the cycle a loader word is
    // accepted; it is stalled only while the word is written to memory.
    assign fetch_stall = (r_state != IDLE) || w_boot_hold;
    assign out_inst    = (!fetch_stall && fetch_req) ? mem_rdata : 32'd0;
    assign oob_err     = r_oob_err;

endmodule
